// File: rtl/keypad_letter_fsm_pkg.sv
// keypad_pkg: shared types and tables for the keypad letter sequencer.
//   state_e  : sequencer states
//   key_e    : decoded keypad key codes (numeric value of K0..K9 = digit)
//   ASCII_BASE, letter_off(), letter_cnt() : multi-tap letter tables
package keypad_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_HOLD, ST_SUBMIT} state_e;

  typedef enum logic [4:0] {
    K0, K1, K2, K3, K4, K5, K6, K7, K8, K9,
    KA, KB, KC, KD, KSTAR, KHASH, KNONE
  } key_e;

  localparam logic [7:0] ASCII_BASE = 8'h41;

  // Offset of a key's first letter from 'A'.
  function automatic logic [7:0] letter_off(key_e k);
    case (k)
      K2:      return 8'd0;
      K3:      return 8'd3;
      K4:      return 8'd6;
      K5:      return 8'd9;
      K6:      return 8'd12;
      K7:      return 8'd15;
      K8:      return 8'd19;
      K9:      return 8'd22;
      default: return 8'd0;
    endcase
  endfunction

  // Letters on a key; 0 marks a non-letter key.
  function automatic logic [2:0] letter_cnt(key_e k);
    case (k)
      K2, K3, K4, K5, K6, K8: return 3'd3;
      K7, K9:                 return 3'd4;
      default:                return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/keypad_letter_fsm_if.sv
// keypad_letter_fsm_if: scanner + game-logic signals of the letter sequencer.
//   game_active, cur_key, strobe        : into the sequencer
//   scan_enable, scan_mode              : out to the scanner
//   letter, letter_valid, submit        : out to the game logic
// slave = sequencer side, master = driver side.
interface keypad_letter_fsm_if;
  logic       game_active;
  logic [7:0] cur_key;
  logic       strobe;
  logic       scan_enable;
  logic       scan_mode;
  logic [7:0] letter;
  logic       letter_valid;
  logic       submit;

  modport slave  (input  game_active, cur_key, strobe,
                  output scan_enable, scan_mode, letter, letter_valid, submit);
  modport master (output game_active, cur_key, strobe,
                  input  scan_enable, scan_mode, letter, letter_valid, submit);
endinterface

// File: rtl/keypad_letter_fsm_key_decode.sv
// keypad_key_decode: combinational decode of the scanner's {row, col} code.
//   i_cur_key[7:4] : read_row, bit3 = row0 (exactly one bit set is valid)
//   i_cur_key[3:0] : scan_col, one bit low (0111 = col0 .. 1110 = col3)
//   o_key          : key code, KNONE when invalid
//   o_valid        : decode is a real single key
module keypad_key_decode
  import keypad_pkg::*;
(
  input  logic [7:0] i_cur_key,
  output key_e       o_key,
  output logic       o_valid
);

  logic [1:0] w_row, w_col;
  logic       w_row_ok, w_col_ok;

  always_comb begin
    w_row    = 2'd0;
    w_row_ok = 1'b1;
    case (i_cur_key[7:4])
      4'b1000: w_row = 2'd0;
      4'b0100: w_row = 2'd1;
      4'b0010: w_row = 2'd2;
      4'b0001: w_row = 2'd3;
      default: w_row_ok = 1'b0;
    endcase
    w_col    = 2'd0;
    w_col_ok = 1'b1;
    case (i_cur_key[3:0])
      4'b0111: w_col = 2'd0;
      4'b1011: w_col = 2'd1;
      4'b1101: w_col = 2'd2;
      4'b1110: w_col = 2'd3;
      default: w_col_ok = 1'b0;
    endcase
  end

  assign o_valid = w_row_ok & w_col_ok;

  // Layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  always_comb begin
    o_key = KNONE;
    if (o_valid) begin
      case ({w_row, w_col})
        4'h0: o_key = K1;    4'h1: o_key = K2;    4'h2: o_key = K3;    4'h3: o_key = KA;
        4'h4: o_key = K4;    4'h5: o_key = K5;    4'h6: o_key = K6;    4'h7: o_key = KB;
        4'h8: o_key = K7;    4'h9: o_key = K8;    4'hA: o_key = K9;    4'hB: o_key = KC;
        4'hC: o_key = KSTAR; 4'hD: o_key = K0;    4'hE: o_key = KHASH; 4'hF: o_key = KD;
      endcase
    end
  end

endmodule

// File: rtl/keypad_letter_fsm.sv
// keypad_letter_fsm: drives the keypad scanner and turns key presses into
// multi-tap hangman guesses.
//   clk, nRst : clock, asynchronous active-low reset
//   bus       : keypad_letter_fsm_if.slave (scanner in/out, letter/submit out)
// Parameters: SCAN_DIV (cycles per scan_enable pulse, >=2), TAP_TIMEOUT
// (cycles a press keeps the same-key advance window open).
module keypad_letter_fsm
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 1000,
  parameter int TAP_TIMEOUT = 10_000_000
) (
  input  logic                 clk,
  input  logic                 nRst,
  keypad_letter_fsm_if.slave   bus
);

  localparam int TW = $clog2(TAP_TIMEOUT + 1);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [TW-1:0] TMAX    = TW'(TAP_TIMEOUT);
  localparam logic [DW-1:0] DIV_TOP = DW'(SCAN_DIV - 1);

  // ---------------- scan divider ----------------
  logic [DW-1:0] r_div;
  logic          r_scan_mode;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_div       <= '0;
      r_scan_mode <= 1'b0;
    end else begin
      r_scan_mode <= bus.game_active;
      if (!bus.game_active || r_div == DIV_TOP) r_div <= '0;
      else                                      r_div <= r_div + DW'(1);
    end
  end

  assign bus.scan_enable = (r_div == DIV_TOP);
  assign bus.scan_mode   = r_scan_mode;

  // ---------------- key decode ----------------
  key_e w_dec_key;
  logic w_dec_valid;

  keypad_key_decode u_dec (
    .i_cur_key (bus.cur_key),
    .o_key     (w_dec_key),
    .o_valid   (w_dec_valid)
  );

  logic w_evt, w_is_letter;
  assign w_evt       = bus.strobe & w_dec_valid & bus.game_active;
  assign w_is_letter = (letter_cnt(w_dec_key) != 3'd0);

  // ---------------- FSM ----------------
  state_e        r_state, w_nxt_state;
  key_e          r_key, w_nxt_key;
  logic [1:0]    r_idx, w_nxt_idx;
  logic [TW-1:0] r_timer, w_nxt_timer;
  logic [2:0]    w_idx_inc;
  logic [7:0]    r_letter;
  logic          r_valid, r_submit;

  assign w_idx_inc = {1'b0, r_idx} + 3'd1;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_key   = r_key;
    w_nxt_idx   = r_idx;
    w_nxt_timer = r_timer;
    case (r_state)
      ST_IDLE: begin
        if (w_evt && w_is_letter) begin
          w_nxt_state = ST_SELECT;
          w_nxt_key   = w_dec_key;
          w_nxt_idx   = 2'd0;
        end
      end
      ST_SELECT: begin
        if (r_timer != TMAX) w_nxt_timer = r_timer + TW'(1);
        // A press takes priority over the timeout in the same cycle.
        if (w_evt && w_is_letter) begin
          w_nxt_timer = '0;
          if (w_dec_key == r_key) begin
            w_nxt_idx = (w_idx_inc == letter_cnt(r_key)) ? 2'd0 : w_idx_inc[1:0];
          end else begin
            w_nxt_key = w_dec_key;
            w_nxt_idx = 2'd0;
          end
        end else if (w_evt && w_dec_key == KSTAR) begin
          w_nxt_state = ST_IDLE;
        end else if (w_evt && w_dec_key == KHASH) begin
          w_nxt_state = ST_SUBMIT;
        end else if (r_timer == TMAX) begin
          w_nxt_state = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (w_evt && w_is_letter) begin
          w_nxt_state = ST_SELECT;
          w_nxt_key   = w_dec_key;
          w_nxt_idx   = 2'd0;
        end else if (w_evt && w_dec_key == KSTAR) begin
          w_nxt_state = ST_IDLE;
        end else if (w_evt && w_dec_key == KHASH) begin
          w_nxt_state = ST_SUBMIT;
        end
      end
      ST_SUBMIT: w_nxt_state = ST_IDLE;  // strobes here are dropped
      default:   w_nxt_state = ST_IDLE;
    endcase
    if (!bus.game_active) w_nxt_state = ST_IDLE;
    // Timer only runs while in SELECT; entering SELECT always starts at 0.
    if (w_nxt_state != ST_SELECT || r_state != ST_SELECT) w_nxt_timer = '0;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state  <= ST_IDLE;
      r_key    <= KNONE;
      r_idx    <= 2'd0;
      r_timer  <= '0;
      r_letter <= 8'h00;
      r_valid  <= 1'b0;
      r_submit <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_key    <= w_nxt_key;
      r_idx    <= w_nxt_idx;
      r_timer  <= w_nxt_timer;
      // Outputs are registered off the next state so they track r_state.
      r_valid  <= (w_nxt_state != ST_IDLE);
      r_submit <= (w_nxt_state == ST_SUBMIT);
      r_letter <= (w_nxt_state == ST_IDLE) ? 8'h00
                : ASCII_BASE + letter_off(w_nxt_key) + {6'b0, w_nxt_idx};
    end
  end

  assign bus.letter       = r_letter;
  assign bus.letter_valid = r_valid;
  assign bus.submit       = r_submit;

endmodule

// File: tb/tb_keypad_letter_fsm.sv
// Bench for keypad_letter_fsm: directed scenarios then random key streams
// against a multi-tap model working on characters and press timestamps.
module tb_keypad_letter_fsm;

  localparam int T  = 20;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic nRst;
  always #5 clk = ~clk;

  keypad_letter_fsm_if bus();

  keypad_letter_fsm #(.SCAN_DIV(SD), .TAP_TIMEOUT(T)) dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // model: pending letter = letters[m_key][m_taps % len]
  string letters [10] = '{"", "", "ABC", "DEF", "GHI", "JKL", "MNO", "PQRS", "TUV", "WXYZ"};
  string layout = "123A456B789C*0#D";
  bit m_pend, m_subm, exp_sub;
  int m_key, m_taps, m_last;

  function automatic logic [7:0] code_of(byte ch);
    logic [3:0] rb, cb;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (layout[r*4+c] == ch) begin
          rb = 4'b1000 >> r;
          cb = 4'hF ^ (4'b1000 >> c);
          return {rb, cb};
        end
    return 8'h00;
  endfunction

  function automatic byte char_of(logic [7:0] code);
    for (int i = 0; i < 16; i++)
      if (code_of(layout[i]) == code) return layout[i];
    return 8'h00;
  endfunction

  function automatic logic [7:0] exp_letter();
    if (!m_pend) return 8'h00;
    return letters[m_key][m_taps % letters[m_key].len()];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step(input bit stb, input logic [7:0] key, input bit ga);
    byte ch;
    exp_sub = 1'b0;
    if (m_subm) begin
      m_subm = 1'b0;
      m_pend = 1'b0;
    end else if (!ga) begin
      m_pend = 1'b0;
    end else if (stb) begin
      ch = char_of(key);
      if (ch >= "2" && ch <= "9") begin
        if (m_pend && (ch - "0") == m_key && (cyc - m_last) <= T + 1) m_taps++;
        else begin
          m_key  = ch - "0";
          m_taps = 0;
        end
        m_pend = 1'b1;
        m_last = cyc;
      end else if (ch == "*") begin
        m_pend = 1'b0;
      end else if (ch == "#" && m_pend) begin
        exp_sub = 1'b1;
        m_subm  = 1'b1;
      end
    end
  endtask

  task automatic check_out();
    chk("submit", bus.submit, exp_sub);
    chk("letter_valid", bus.letter_valid, m_pend);
    chk("letter", bus.letter, exp_letter());
    chk("scan_mode", bus.scan_mode, bus.game_active);
  endtask

  task automatic tick(input bit stb, input logic [7:0] key);
    bus.strobe  = stb;
    bus.cur_key = key;
    @(posedge clk);
    cyc++;
    model_step(stb, key, bus.game_active);
    #1;
    bus.strobe  = 1'b0;
    bus.cur_key = 8'h00;
    check_out();
  endtask

  task automatic press(input logic [7:0] key);
    tick(1'b1, key);
    tick(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic do_reset(input string tag);
    nRst = 1'b0;
    #1;
    chk({tag, "_letter"}, bus.letter, 8'h00);
    chk({tag, "_valid"}, bus.letter_valid, 1'b0);
    chk({tag, "_submit"}, bus.submit, 1'b0);
    chk({tag, "_scan_en"}, bus.scan_enable, 1'b0);
    chk({tag, "_scan_mode"}, bus.scan_mode, 1'b0);
    m_pend = 0; m_subm = 0; exp_sub = 0;
    @(negedge clk);
    nRst = 1'b1;
  endtask

  logic [7:0] pool [24];
  int gap;

  initial begin
    bus.game_active = 1'b0;
    bus.strobe      = 1'b0;
    bus.cur_key     = 8'h00;
    nRst            = 1'b0;
    m_pend = 0; m_subm = 0; exp_sub = 0; m_key = 0; m_taps = 0; m_last = 0;
    #12;
    do_reset("reset");

    // Scan divider: silent while inactive, then every SD-th cycle.
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 8'h00);
      chk("scan_idle", bus.scan_enable, 1'b0);
    end
    bus.game_active = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0, 8'h00);
      chk("scan_pulse", bus.scan_enable, (i % SD) == SD - 1);
    end

    // 1: '2' then '#' -> 'A'
    press(8'h8B);
    tick(1'b1, 8'h1D);
    chk("t1_submit", bus.submit, 1'b1);
    chk("t1_letter", bus.letter, 8'h41);
    tick(1'b0, 8'h00);
    chk("t1_after", bus.letter_valid, 1'b0);

    // 2: '7' x5 -> wraps to 'P'
    for (int i = 0; i < 5; i++) press(8'h27);
    tick(1'b1, 8'h1D);
    chk("t2_letter", bus.letter, 8'h50);
    chk("t2_submit", bus.submit, 1'b1);
    idle(2);

    // 3: '9' x2, window expires, '9' -> 'W'
    press(8'h2D); press(8'h2D);
    chk("t3_x", bus.letter, 8'h58);
    idle(T + 5);
    tick(1'b1, 8'h2D);
    chk("t3_letter", bus.letter, 8'h57);
    press(8'h17);

    // Window boundary: press exactly T+1 edges later still advances.
    tick(1'b1, 8'h2B);
    idle(T);
    tick(1'b1, 8'h2B);
    chk("edge_in", bus.letter, 8'h55);
    idle(T + 1);
    tick(1'b1, 8'h2B);
    chk("edge_out", bus.letter, 8'h54);
    press(8'h17);

    // 4: '3' x2, '*', '#' -> nothing pending, no submit
    press(8'h8D); press(8'h8D);
    chk("t4_sel", bus.letter, 8'h45);
    press(8'h17);
    press(8'h1D);
    chk("t4_valid", bus.letter_valid, 1'b0);
    press(8'hAD);  // two rows set: ignored
    chk("t4_two_rows", bus.letter_valid, 1'b0);

    // 5: junk strobes and '#' in IDLE
    press(8'h00); press(8'hCB); press(8'h1D); press(8'h87); press(8'h1B); press(8'h8E);
    chk("t5_idle", bus.letter_valid, 1'b0);
    press(8'h4B);               // '5'
    press(8'hCB);               // ignored inside SELECT
    chk("t5_sel", bus.letter, 8'h4A);
    press(8'h17);

    // Strobe during the SUBMIT cycle is dropped.
    tick(1'b1, 8'h8B);
    tick(1'b1, 8'h1D);
    tick(1'b1, 8'h8B);
    chk("drop", bus.letter_valid, 1'b0);

    // game_active falls mid-SELECT
    press(8'h47);
    bus.game_active = 1'b0;
    tick(1'b0, 8'h00);
    chk("ga_fall", bus.letter_valid, 1'b0);
    bus.game_active = 1'b1;
    idle(1);

    // Reset mid-SELECT
    press(8'h4D);
    chk("pre_rst", bus.letter_valid, 1'b1);
    do_reset("midrst");

    // Random streams
    for (int i = 0; i < 8; i++) begin
      byte ch;
      ch = layout[i < 4 ? i + 4 : i + 4];
      pool[i] = code_of(ch);
    end
    pool[0] = code_of("2");  pool[1] = code_of("3");  pool[2] = code_of("4");
    pool[3] = code_of("5");  pool[4] = code_of("6");  pool[5] = code_of("7");
    pool[6] = code_of("8");  pool[7] = code_of("9");  pool[8] = code_of("7");
    pool[9] = code_of("9");  pool[10] = code_of("2"); pool[11] = code_of("7");
    pool[12] = code_of("9"); pool[13] = code_of("#"); pool[14] = code_of("#");
    pool[15] = code_of("*"); pool[16] = code_of("0"); pool[17] = code_of("1");
    pool[18] = code_of("A"); pool[19] = code_of("D"); pool[20] = 8'h00;
    pool[21] = 8'hCB;        pool[22] = 8'hAD;        pool[23] = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: gap = 0;
        5, 6:          gap = $urandom_range(1, 4);
        default:       gap = $urandom_range(T - 2, T + 4);
      endcase
      idle(gap);
      bus.game_active = ($urandom_range(0, 49) != 0);
      tick(1'b1, pool[$urandom_range(0, 23)]);
      bus.game_active = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
